// File: rtl/piso_pingpong_layer.sv
// Parallel-in, multi-lane serial-out layer with two ping-pong buffer banks.
// A vector is captured whole into one bank while the other bank drains
// LANES words per beat, so back-to-back vectors stream without a bubble.
module piso_pingpong_layer #(
  parameter int unsigned MAX_INPUT_SIZE = 8,
  parameter int unsigned WORD_SIZE      = 16,
  parameter int unsigned LANES          = 2
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic                                valid_i,
  output logic                                ready_o,
  input  logic [MAX_INPUT_SIZE*WORD_SIZE-1:0] data_i,
  input  logic [$clog2(MAX_INPUT_SIZE+1)-1:0] data_size_i,
  output logic                                valid_o,
  input  logic                                ready_i,
  output logic [LANES*WORD_SIZE-1:0]          data_o,
  output logic [LANES-1:0]                    keep_o,
  output logic                                last_o
);

  localparam int unsigned SizeW    = $clog2(MAX_INPUT_SIZE + 1);
  localparam int unsigned MaxBeats = (MAX_INPUT_SIZE + LANES - 1) / LANES;
  localparam int unsigned BeatW    = $clog2(MaxBeats + 1);
  localparam int unsigned IdxW     = $clog2(MAX_INPUT_SIZE + LANES + 1);
  localparam int unsigned VecW     = MAX_INPUT_SIZE * WORD_SIZE;

  logic [1:0]       occ_q, occ_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [BeatW-1:0] beat_q, beat_d;
  logic [VecW-1:0]  bank_q [2];
  logic [VecW-1:0]  bank_d [2];
  logic [SizeW-1:0] size_q [2];
  logic [SizeW-1:0] size_d [2];

  logic [SizeW-1:0] size_in;
  logic [SizeW-1:0] rd_size;
  logic [IdxW-1:0]  beats;
  logic [IdxW-1:0]  idx;
  logic             last_beat;
  logic             accept, store, fire, fin;

  // Handshake flags come straight from occupancy; ready_i never reaches ready_o.
  assign ready_o = ~reset_i & (occ_q != 2'd2);
  assign valid_o = (occ_q != 2'd0);

  // Clamp the incoming size and work out the geometry of the draining bank.
  always_comb begin
    size_in   = (data_size_i > SizeW'(MAX_INPUT_SIZE)) ? SizeW'(MAX_INPUT_SIZE) : data_size_i;
    rd_size   = size_q[rd_ptr_q];
    beats     = (IdxW'(rd_size) + IdxW'(LANES - 1)) / IdxW'(LANES);
    last_beat = (IdxW'(beat_q) == beats - IdxW'(1));
  end

  // Output beat: lanes past the end of the vector are zeroed with keep cleared.
  always_comb begin
    data_o = '0;
    keep_o = '0;
    last_o = 1'b0;
    idx    = '0;
    if (valid_o) begin
      last_o = last_beat;
      for (int j = 0; j < LANES; j++) begin
        idx = IdxW'(beat_q) * IdxW'(LANES) + IdxW'(j);
        if (idx < IdxW'(rd_size)) begin
          keep_o[j] = 1'b1;
          for (int k = 0; k < MAX_INPUT_SIZE; k++) begin
            if (idx == IdxW'(k)) begin
              data_o[j*WORD_SIZE +: WORD_SIZE] = bank_q[rd_ptr_q][k*WORD_SIZE +: WORD_SIZE];
            end
          end
        end
      end
    end
  end

  // Next-state for occupancy, bank pointers, beat counter and bank contents.
  always_comb begin
    accept   = valid_i & ready_o;
    // A zero-length vector completes the handshake but occupies no bank.
    store    = accept & (size_in != '0);
    fire     = valid_o & ready_i;
    fin      = fire & last_beat;
    occ_d    = occ_q;
    if (store && !fin) begin
      occ_d = occ_q + 2'd1;
    end else if (fin && !store) begin
      occ_d = occ_q - 2'd1;
    end
    wr_ptr_d = wr_ptr_q ^ store;
    rd_ptr_d = rd_ptr_q ^ fin;
    if (fin) begin
      beat_d = '0;
    end else if (fire) begin
      beat_d = beat_q + BeatW'(1);
    end else begin
      beat_d = beat_q;
    end
    bank_d = bank_q;
    size_d = size_q;
    if (store) begin
      bank_d[wr_ptr_q] = data_i;
      size_d[wr_ptr_q] = size_in;
    end
  end

  // Control state, cleared asynchronously.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      occ_q    <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      beat_q   <= '0;
    end else begin
      occ_q    <= occ_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      beat_q   <= beat_d;
    end
  end

  // Bank storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_i) begin
    bank_q <= bank_d;
    size_q <= size_d;
  end

endmodule

// File: tb/tb_piso_pingpong_layer.sv
// Bench for piso_pingpong_layer: a queue-of-vectors model predicts every beat,
// compared on each falling edge, plus literal expectations on directed cases.
module tb_piso_pingpong_layer;

  logic         clk_i = 1'b0;
  logic         reset_i, valid_i, ready_o, valid_o, ready_i, last_o;
  logic [127:0] data_i;
  logic [3:0]   data_size_i;
  logic [31:0]  data_o;
  logic [1:0]   keep_o;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] w [8];
    int          n;
  } vec_t;

  vec_t mq[$];
  int   mb = 0;

  piso_pingpong_layer #(
    .MAX_INPUT_SIZE(8),
    .WORD_SIZE     (16),
    .LANES         (2)
  ) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .data_i     (data_i),
    .data_size_i(data_size_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .data_o     (data_o),
    .keep_o     (keep_o),
    .last_o     (last_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic vec_t mkvec(logic [127:0] d, int sz);
    vec_t v;
    for (int i = 0; i < 8; i++) v.w[i] = d[i*16 +: 16];
    v.n = (sz > 8) ? 8 : sz;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model view: head of queue is draining, mb is its beat number.
  task automatic compare();
    logic        ev, er, el;
    logic [31:0] ed;
    logic [1:0]  ek;
    int          idx;
    ev = (mq.size() > 0);
    er = !reset_i && (mq.size() < 2);
    ed = '0;
    ek = '0;
    el = 1'b0;
    if (ev) begin
      for (int j = 0; j < 2; j++) begin
        idx = mb * 2 + j;
        if (idx < mq[0].n) begin
          ed[j*16 +: 16] = mq[0].w[idx];
          ek[j] = 1'b1;
        end
      end
      el = ((mb + 1) * 2 >= mq[0].n);
    end
    chk("valid_o", {31'd0, valid_o}, {31'd0, ev});
    chk("ready_o", {31'd0, ready_o}, {31'd0, er});
    chk("data_o", data_o, ed);
    chk("keep_o", {30'd0, keep_o}, {30'd0, ek});
    chk("last_o", {31'd0, last_o}, {31'd0, el});
  endtask

  // One clock: compare, drive, advance the model across the rising edge.
  task automatic tick(input logic v, input logic [3:0] sz, input logic [127:0] d,
                      input logic r, output bit acc);
    bit pre_v, fire, fin;
    @(negedge clk_i);
    compare();
    valid_i     = v;
    data_size_i = sz;
    data_i      = d;
    ready_i     = r;
    pre_v = (mq.size() > 0);
    acc   = v && (mq.size() < 2);
    fire  = pre_v && r;
    fin   = fire && ((mb + 1) * 2 >= mq[0].n);
    @(posedge clk_i);
    if (fin) begin
      void'(mq.pop_front());
      mb = 0;
    end else if (fire) begin
      mb++;
    end
    if (acc && sz != 4'd0) mq.push_back(mkvec(d, int'(sz)));
    #1;
  endtask

  // Asynchronous reset pulse starting mid-cycle, released on the falling edge.
  task automatic do_reset_async();
    #1;
    reset_i = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b0;
    mq.delete();
    mb = 0;
    #1;
    chk("rst_async_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_async_ready", {31'd0, ready_o}, 32'd0);
    @(negedge clk_i);
    compare();
    reset_i = 1'b0;
    #1;
    chk("rst_release_ready", {31'd0, ready_o}, 32'd1);
    chk("rst_release_valid", {31'd0, valid_o}, 32'd0);
  endtask

  logic [127:0] d, d2;
  bit           a;
  int           got;

  initial begin
    reset_i     = 1'b1;
    valid_i     = 1'b0;
    ready_i     = 1'b0;
    data_i      = '0;
    data_size_i = '0;
    repeat (2) @(negedge clk_i);
    compare();
    reset_i = 1'b0;
    #1;
    chk("init_ready", {31'd0, ready_o}, 32'd1);
    chk("init_valid", {31'd0, valid_o}, 32'd0);

    // Size-5 vector: three beats, last one half-filled.
    d = '0;
    for (int i = 0; i < 5; i++) d[i*16 +: 16] = 16'h0011 + 16'(i);
    tick(1'b1, 4'd5, d, 1'b1, a);
    chk("t1_b0_data", data_o, 32'h0012_0011);
    chk("t1_b0_keep", {30'd0, keep_o}, 32'd3);
    chk("t1_b0_last", {31'd0, last_o}, 32'd0);
    tick(1'b0, 4'd0, '0, 1'b1, a);
    chk("t1_b1_data", data_o, 32'h0014_0013);
    tick(1'b0, 4'd0, '0, 1'b1, a);
    chk("t1_b2_data", data_o, 32'h0000_0015);
    chk("t1_b2_keep", {30'd0, keep_o}, 32'd1);
    chk("t1_b2_last", {31'd0, last_o}, 32'd1);
    tick(1'b0, 4'd0, '0, 1'b1, a);
    chk("t1_idle_valid", {31'd0, valid_o}, 32'd0);

    // Three size-4 vectors offered back to back; third waits for a free bank.
    got = 0;
    for (int k = 0; k < 10 && got < 3; k++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      tick(1'b1, 4'd4, d, 1'b1, a);
      if (a) got++;
      if (k == 1) chk("t2_full_ready", {31'd0, ready_o}, 32'd0);
    end
    chk("t2_accepted", got, 3);
    repeat (7) tick(1'b0, 4'd0, '0, 1'b1, a);

    // Size-6 vector stalled on beat 1 for three cycles.
    d = '0;
    for (int i = 0; i < 6; i++) d[i*16 +: 16] = 16'h0a00 + 16'(i);
    tick(1'b1, 4'd6, d, 1'b1, a);
    tick(1'b0, 4'd0, '0, 1'b1, a);
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 4'd0, '0, 1'b0, a);
      chk("t3_hold_data", data_o, 32'h0a03_0a02);
      chk("t3_hold_last", {31'd0, last_o}, 32'd0);
    end
    repeat (4) tick(1'b0, 4'd0, '0, 1'b1, a);

    // Size 0 produces nothing; size 9 clamps to 8 words / 4 beats.
    tick(1'b1, 4'd0, '1, 1'b1, a);
    chk("t4_zero_accept", {31'd0, a}, 32'd1);
    chk("t4_zero_valid", {31'd0, valid_o}, 32'd0);
    d = {$urandom, $urandom, $urandom, $urandom};
    tick(1'b1, 4'd9, d, 1'b1, a);
    for (int b = 0; b < 4; b++) begin
      chk("t4_clamp_keep", {30'd0, keep_o}, 32'd3);
      chk("t4_clamp_last", {31'd0, last_o}, (b == 3) ? 32'd1 : 32'd0);
      tick(1'b0, 4'd0, '0, 1'b1, a);
    end
    chk("t4_clamp_done", {31'd0, valid_o}, 32'd0);

    // Async reset during beat 1 with a second vector queued.
    d = {$urandom, $urandom, $urandom, $urandom};
    tick(1'b1, 4'd8, d, 1'b1, a);
    tick(1'b1, 4'd8, ~d, 1'b1, a);
    do_reset_async();
    d = 128'h0;
    d[15:0]  = 16'hbeef;
    d[31:16] = 16'hcafe;
    d[47:32] = 16'h1234;
    tick(1'b1, 4'd3, d, 1'b1, a);
    chk("t5_restart_data", data_o, 32'hcafe_beef);
    tick(1'b0, 4'd0, '0, 1'b1, a);
    chk("t5_restart_b1", data_o, 32'h0000_1234);
    tick(1'b0, 4'd0, '0, 1'b1, a);

    // New vector accepted in the same cycle the last beat drains: no bubble.
    d  = 128'h0;
    d[31:0]  = 32'h2222_1111;
    d2 = 128'h0;
    d2[31:0] = 32'h4444_3333;
    tick(1'b1, 4'd2, d, 1'b1, a);
    chk("t6_first_last", {31'd0, last_o}, 32'd1);
    tick(1'b1, 4'd2, d2, 1'b1, a);
    chk("t6_accept", {31'd0, a}, 32'd1);
    chk("t6_nobubble_valid", {31'd0, valid_o}, 32'd1);
    chk("t6_nobubble_data", data_o, 32'h4444_3333);
    tick(1'b0, 4'd0, '0, 1'b1, a);

    // Randomized traffic with occasional asynchronous resets.
    for (int it = 0; it < 1500; it++) begin
      logic [3:0] sz;
      sz = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      d  = {$urandom, $urandom, $urandom, $urandom};
      tick(1'($urandom_range(0, 9) < 6), sz, d, 1'($urandom_range(0, 9) < 7), a);
      if ($urandom_range(0, 299) == 0) do_reset_async();
    end
    repeat (12) tick(1'b0, 4'd0, '0, 1'b1, a);
    chk("final_drained", {31'd0, valid_o}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
